// File: rtl/qam_symbol_gen_check.sv
// Symbol source + loopback checker: data_out registered, each symbol held HOLD_CYCLES clocks; compares demod_in at
// mid-symbol after LAT_CYCLES, result registered one clock later; no backpressure, enable=0 freezes the sequence.
module qam_symbol_gen_check #(
    parameter int SYM_BITS    = 2,
    parameter int HOLD_CYCLES = 8000,
    parameter int LAT_CYCLES  = 16,
    parameter int CNT_W       = 16,
    parameter int LOCK_N      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [SYM_BITS-1:0] const_sym,
    input  logic [SYM_BITS-1:0] demod_in,
    output logic [SYM_BITS-1:0] data_out,
    output logic                sym_strobe,
    output logic [CNT_W-1:0]    sym_count,
    output logic [CNT_W-1:0]    err_count,
    output logic                locked
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GR_W = $clog2(LOCK_N + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_MID  = HC_W'(HOLD_CYCLES / 2);
    localparam logic [GR_W-1:0] GOOD_MAX  = GR_W'(LOCK_N);
    localparam logic [GR_W-1:0] GOOD_PRE  = GR_W'(LOCK_N - 1);

    logic [HC_W-1:0]     hold_cnt;
    logic [6:0]          lfsr;
    logic [6:0]          lfsr_nxt;
    logic                prbs_bit;
    logic [SYM_BITS-1:0] prbs_sym;
    logic [SYM_BITS-1:0] next_sym;
    logic [GR_W-1:0]     good_run;
    logic                boundary;
    logic                mid;
    logic [SYM_BITS:0]   dly [LAT_CYCLES];
    logic [SYM_BITS-1:0] exp_sym;
    logic                exp_mid;

    assign boundary = enable && (hold_cnt == HOLD_LAST);
    assign mid      = enable && (hold_cnt == HOLD_MID);
    assign exp_sym  = dly[LAT_CYCLES-1][SYM_BITS:1];
    assign exp_mid  = dly[LAT_CYCLES-1][0];

    // PRBS7 stepped SYM_BITS times; the earliest generated bit lands in the MSB
    always_comb begin
        lfsr_nxt = lfsr;
        prbs_bit = 1'b0;
        prbs_sym = '0;
        for (int i = 0; i < SYM_BITS; i++) begin
            prbs_bit = lfsr_nxt[6] ^ lfsr_nxt[5];
            lfsr_nxt = {lfsr_nxt[5:0], prbs_bit};
            prbs_sym[SYM_BITS-1-i] = prbs_bit;
        end
    end

    always_comb begin
        next_sym = data_out;
        case (mode)
            2'd0:    next_sym = data_out + SYM_BITS'(1);
            2'd1:    next_sym = prbs_sym;
            2'd2:    next_sym = const_sym;
            default: next_sym = (data_out != const_sym) ? const_sym : ~const_sym;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            data_out   <= '0;
            sym_strobe <= 1'b0;
            lfsr       <= 7'h7F;
            sym_count  <= '0;
        end else if (boundary) begin
            hold_cnt   <= '0;
            data_out   <= next_sym;
            sym_strobe <= 1'b1;
            if (mode == 2'd1) begin
                lfsr <= lfsr_nxt;
            end
            if (sym_count != '1) begin
                sym_count <= sym_count + CNT_W'(1);
            end
        end else begin
            sym_strobe <= 1'b0;
            if (enable) begin
                hold_cnt <= hold_cnt + HC_W'(1);
            end
        end
    end

    // Delay line keeps shifting while disabled so stale mid flags drain out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT_CYCLES; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= {data_out, mid};
            for (int i = 1; i < LAT_CYCLES; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            good_run  <= '0;
            locked    <= 1'b0;
        end else if (exp_mid) begin
            if (demod_in != exp_sym) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
                good_run <= '0;
                locked   <= 1'b0;
            end else begin
                if (good_run != GOOD_MAX) begin
                    good_run <= good_run + GR_W'(1);
                end
                if (good_run >= GOOD_PRE) begin
                    locked <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_qam_symbol_gen_check.sv
// Directed bench: three instances cover 2-bit counting/lock, 1-bit PRBS7 and 4-bit counter saturation.
module tb_qam_symbol_gen_check;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       rst_a, en_a, st_a, lk_a;
    logic [1:0] mode_a, cs_a, dm_a, do_a;
    logic [15:0] sc_a, ec_a;

    logic       rst_p, en_p, st_p, lk_p, cs_p, dm_p, do_p;
    logic [1:0] mode_p;
    logic [15:0] sc_p, ec_p;

    logic       rst_c, en_c, st_c, lk_c;
    logic [1:0] mode_c, cs_c, dm_c, do_c;
    logic [3:0] sc_c, ec_c;

    logic [1:0] hist_a [4];
    logic       corrupt;

    qam_symbol_gen_check #(.SYM_BITS(2), .HOLD_CYCLES(4), .LAT_CYCLES(3), .CNT_W(16), .LOCK_N(4)) u_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .mode(mode_a), .const_sym(cs_a), .demod_in(dm_a),
        .data_out(do_a), .sym_strobe(st_a), .sym_count(sc_a), .err_count(ec_a), .locked(lk_a));

    qam_symbol_gen_check #(.SYM_BITS(1), .HOLD_CYCLES(4), .LAT_CYCLES(3), .CNT_W(16), .LOCK_N(4)) u_p (
        .clk(clk), .rst(rst_p), .enable(en_p), .mode(mode_p), .const_sym(cs_p), .demod_in(dm_p),
        .data_out(do_p), .sym_strobe(st_p), .sym_count(sc_p), .err_count(ec_p), .locked(lk_p));

    qam_symbol_gen_check #(.SYM_BITS(2), .HOLD_CYCLES(4), .LAT_CYCLES(3), .CNT_W(4), .LOCK_N(4)) u_c (
        .clk(clk), .rst(rst_c), .enable(en_c), .mode(mode_c), .const_sym(cs_c), .demod_in(dm_c),
        .data_out(do_c), .sym_strobe(st_c), .sym_count(sc_c), .err_count(ec_c), .locked(lk_c));

    // Advance one clock, then model a 3-register demod pipeline fed from data_out of instance A
    task tick();
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) hist_a[i] = hist_a[i-1];
        hist_a[0] = do_a;
        dm_a = corrupt ? ~hist_a[3] : hist_a[3];
    endtask

    task test_reset();
        rst_a = 1'b1; rst_p = 1'b1; rst_c = 1'b1;
        en_a = 1'b0; en_p = 1'b0; en_c = 1'b0;
        mode_a = 2'd0; mode_p = 2'd1; mode_c = 2'd3;
        cs_a = 2'd0; cs_p = 1'b0; cs_c = 2'd1;
        dm_a = 2'd0; dm_p = 1'b0; dm_c = 2'd3;
        corrupt = 1'b0;
        for (int i = 0; i < 4; i++) hist_a[i] = 2'd0;
        tick();
        tick();
        n_cmp++; if (do_a !== 2'd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", do_a); end
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %0b want 0", st_a); end
        n_cmp++; if (sc_a !== 16'd0) begin n_bad++; $display("FAIL reset_sym_count got %0d want 0", sc_a); end
        n_cmp++; if (ec_a !== 16'd0) begin n_bad++; $display("FAIL reset_err_count got %0d want 0", ec_a); end
        n_cmp++; if (lk_a !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %0b want 0", lk_a); end
    endtask

    // Enabled edge k: data_out = ((k+1)/4) mod 4, strobe when k mod 4 == 3; compares land on edges 5,9,13,17,...
    task test_count_mode();
        logic [1:0] exp_d;
        rst_a = 1'b0;
        en_a = 1'b1;
        mode_a = 2'd0;
        for (int k = 0; k <= 17; k++) begin
            tick();
            exp_d = 2'((k + 1) / 4);
            n_cmp++; if (do_a !== exp_d) begin n_bad++; $display("FAIL count_data k=%0d got %0d want %0d", k, do_a, exp_d); end
            n_cmp++; if (st_a !== (k % 4 == 3)) begin n_bad++; $display("FAIL count_strobe k=%0d got %0b", k, st_a); end
            if (k == 16) begin
                n_cmp++; if (lk_a !== 1'b0) begin n_bad++; $display("FAIL early_lock got %0b want 0", lk_a); end
            end
        end
        n_cmp++; if (lk_a !== 1'b1) begin n_bad++; $display("FAIL lock_after_4 got %0b want 1", lk_a); end
        n_cmp++; if (ec_a !== 16'd0) begin n_bad++; $display("FAIL count_errs got %0d want 0", ec_a); end
    endtask

    // Demod corrupted for the symbol compared on edge 21
    task test_error();
        logic [1:0] exp_d;
        for (int k = 18; k <= 40; k++) begin
            corrupt = (k >= 18 && k <= 21);
            tick();
            exp_d = 2'((k + 1) / 4);
            n_cmp++; if (do_a !== exp_d) begin n_bad++; $display("FAIL err_data k=%0d got %0d want %0d", k, do_a, exp_d); end
            if (k == 20) begin
                n_cmp++; if (ec_a !== 16'd0 || lk_a !== 1'b1) begin n_bad++; $display("FAIL pre_error ec=%0d lk=%0b want 0/1", ec_a, lk_a); end
            end
            if (k == 21) begin
                n_cmp++; if (ec_a !== 16'd1 || lk_a !== 1'b0) begin n_bad++; $display("FAIL on_error ec=%0d lk=%0b want 1/0", ec_a, lk_a); end
            end
            if (k == 36) begin
                n_cmp++; if (lk_a !== 1'b0) begin n_bad++; $display("FAIL relock_early got %0b want 0", lk_a); end
            end
            if (k == 37) begin
                n_cmp++; if (lk_a !== 1'b1) begin n_bad++; $display("FAIL relock got %0b want 1", lk_a); end
            end
        end
        corrupt = 1'b0;
    endtask

    // Frozen with hold_cnt=1, data_out=2: resume needs 1->2, 2->3, then the boundary edge
    task test_enable_freeze();
        en_a = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_cmp++; if (do_a !== 2'd2 || st_a !== 1'b0) begin n_bad++; $display("FAIL freeze j=%0d data=%0d strobe=%0b want 2/0", j, do_a, st_a); end
        end
        en_a = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick();
            n_cmp++; if (st_a !== (j == 3)) begin n_bad++; $display("FAIL resume_strobe j=%0d got %0b", j, st_a); end
        end
        n_cmp++; if (do_a !== 2'd3) begin n_bad++; $display("FAIL resume_data got %0d want 3", do_a); end
        tick();
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL strobe_width got %0b want 0", st_a); end
        n_cmp++; if (ec_a !== 16'd1) begin n_bad++; $display("FAIL freeze_errs got %0d want 1", ec_a); end
    endtask

    // PRBS7 x^7+x^6+1 from 7'h7F, one new bit per 1-bit symbol; 130 symbols spans a full 127 period
    task test_prbs();
        logic [6:0] l;
        logic       nb;
        int         gap;
        int         nsym;
        l = 7'h7F;
        gap = 0;
        nsym = 0;
        rst_p = 1'b0;
        en_p = 1'b1;
        mode_p = 2'd1;
        for (int t = 0; t < 130 * 4; t++) begin
            tick();
            gap++;
            if (st_p === 1'b1) begin
                nb = l[6] ^ l[5];
                l = {l[5:0], nb};
                nsym++;
                n_cmp++; if (do_p !== nb) begin n_bad++; $display("FAIL prbs_bit sym=%0d got %0b want %0b", nsym, do_p, nb); end
                n_cmp++; if (gap != 4) begin n_bad++; $display("FAIL prbs_gap sym=%0d got %0d want 4", nsym, gap); end
                gap = 0;
            end
        end
        n_cmp++; if (nsym != 130) begin n_bad++; $display("FAIL prbs_strobes got %0d want 130", nsym); end
        n_cmp++; if (sc_p !== 16'd130) begin n_bad++; $display("FAIL prbs_sym_count got %0d want 130", sc_p); end
    endtask

    // Mode 3 alternates 1,2,1 around const 1; mode 2 const 0 then runs every counter into saturation
    task test_saturate();
        rst_c = 1'b0;
        en_c = 1'b1;
        for (int k = 0; k <= 90; k++) begin
            if (k == 12) begin
                mode_c = 2'd2;
                cs_c = 2'd0;
            end
            tick();
            if (k == 3) begin
                n_cmp++; if (do_c !== 2'd1) begin n_bad++; $display("FAIL alt_1 got %0d want 1", do_c); end
            end
            if (k == 7) begin
                n_cmp++; if (do_c !== 2'd2) begin n_bad++; $display("FAIL alt_2 got %0d want 2", do_c); end
            end
            if (k == 11) begin
                n_cmp++; if (do_c !== 2'd1 || sc_c !== 4'd3) begin n_bad++; $display("FAIL alt_3 data=%0d cnt=%0d want 1/3", do_c, sc_c); end
            end
            if (k == 15) begin
                n_cmp++; if (do_c !== 2'd0) begin n_bad++; $display("FAIL const_0 got %0d want 0", do_c); end
            end
        end
        n_cmp++; if (sc_c !== 4'd15) begin n_bad++; $display("FAIL sym_sat got %0d want 15", sc_c); end
        n_cmp++; if (ec_c !== 4'd15) begin n_bad++; $display("FAIL err_sat got %0d want 15", ec_c); end
        n_cmp++; if (lk_c !== 1'b0) begin n_bad++; $display("FAIL sat_locked got %0b want 0", lk_c); end
    endtask

    // hold_cnt is 3 here, so reset must beat the pending boundary
    task test_reset_mid();
        rst_c = 1'b1;
        tick();
        n_cmp++; if (do_c !== 2'd0 || st_c !== 1'b0) begin n_bad++; $display("FAIL midrst_data data=%0d strobe=%0b want 0/0", do_c, st_c); end
        n_cmp++; if (sc_c !== 4'd0 || ec_c !== 4'd0) begin n_bad++; $display("FAIL midrst_counts sc=%0d ec=%0d want 0/0", sc_c, ec_c); end
        n_cmp++; if (lk_c !== 1'b0) begin n_bad++; $display("FAIL midrst_locked got %0b want 0", lk_c); end
    endtask

    initial begin
        test_reset();
        test_count_mode();
        test_error();
        test_enable_freeze();
        test_prbs();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
